flit_sender: RTL and testbench
==============================

FLIT_SENDER -- requirements
Module: flit_sender

Interface
REQ-001 The module SHALL have parameter DATA_W, default 8, flit width in bits.
REQ-002 The module SHALL have parameter DEPTH, default 4, input FIFO entries (power of two, >=2).
REQ-003 The module SHALL have parameter PKT_LEN, default 4, flits per packet (>=1).
REQ-004 The module SHALL have parameter TIMEOUT, default 15, grant-wait limit in cycles (used only under REQ-028).
REQ-005 clk  input  1  sole clock, rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-high.
REQ-007 in_valid  input  1  upstream flit present.
REQ-008 in_data  input  DATA_W  upstream flit.
REQ-009 in_ready  output  1  FIFO can accept a flit.
REQ-010 req  output  1  request to output-port arbiter.
REQ-011 gnt  input  1  grant from arbiter; arrives >=1 cycle after req and stays high while req is high.
REQ-012 out_valid  output  1  flit on out_data is transferred this cycle.
REQ-013 out_data  output  DATA_W  granted flit.
REQ-014 busy  output  1  state is not IDLE.
REQ-015 timeout_err  output  1  one-cycle pulse; grant-wait abandoned.

Function
REQ-016 FIFO SHALL push when in_valid && in_ready; in_ready = !full; push and pop in the same cycle SHALL leave the count unchanged; the FIFO SHALL never overflow or underflow.
REQ-017 out_data SHALL equal the FIFO head; out_valid SHALL be combinational: (state==SEND) && gnt && !empty; every out_valid cycle pops one flit, in FIFO order.
REQ-018 FSM states: IDLE, REQ, SEND, RELEASE; state and all counters registered.
REQ-019 IDLE: req=0; when FIFO is non-empty, go to REQ next cycle.
REQ-020 REQ: req=1; when gnt==1, go to SEND next cycle; otherwise stay.
REQ-021 SEND: req=1; a 0..PKT_LEN-1 beat counter SHALL increment per out_valid; on the beat where counter==PKT_LEN-1, clear the counter and go to RELEASE.
REQ-022 SEND with FIFO empty or gnt low SHALL stall: out_valid=0, req held high, counter held; the packet resumes without loss or duplication.
REQ-023 RELEASE: req=0; when gnt==0, go to IDLE; a new request SHALL NOT be raised while gnt is still high from the previous packet.
REQ-024 Back-to-back packets SHALL each pass through RELEASE, giving at least one req-low cycle between packets.
REQ-025 busy SHALL be high in REQ, SEND and RELEASE.

Reset
REQ-026 Asserting rst at any time, including mid-packet, SHALL immediately force: state=IDLE, FIFO empty, beat counter=0, req=0, out_valid=0, in_ready=1, busy=0, timeout_err=0; a partial packet is discarded.
REQ-027 After rst deasserts, the first state change SHALL occur on the following rising clk edge.

Configuration
REQ-028 With macro FLIT_SENDER_TIMEOUT_EN defined, a wait counter SHALL count REQ cycles with gnt low; when it reaches TIMEOUT, the FSM SHALL go to IDLE (req drops for at least one cycle), pulse timeout_err for one cycle and keep the FIFO contents. The counter SHALL clear on leaving REQ.
REQ-029 Without FLIT_SENDER_TIMEOUT_EN, REQ SHALL wait indefinitely, timeout_err SHALL be tied to 0 and no wait counter SHALL exist.

Verification
REQ-030 Write 4 flits 0x11..0x14 and hold gnt low until 2 cycles after req rises -> req rises 1 cycle after the first push; out_valid is high for 4 consecutive cycles carrying 0x11..0x14; req falls in the cycle after 0x14.
REQ-031 Write 5 flits with in_valid held high, no pops -> in_ready goes low after the 4th push; the 5th flit is held upstream and is not lost.
REQ-032 Drop gnt for 3 cycles after beat 2 of a packet -> out_valid stays low for 3 cycles with req high, then beats 3-4 follow in order.
REQ-033 Assert rst after beat 2, with 2 flits queued -> all outputs reach reset values in the same cycle; after release, req stays low until new flits are written.
REQ-034 With FLIT_SENDER_TIMEOUT_EN defined, TIMEOUT=15 and gnt never asserted -> timeout_err pulses once 15 cycles after req rises, req drops for >=1 cycle and then re-asserts, and the FIFO count is unchanged.
REQ-035 Write 8 flits and hold gnt high until 1 cycle after req falls -> two 4-flit packets, with req low for >=1 cycle between them and no out_valid during RELEASE.

Source files
------------

// File: rtl/flit_sender.sv
// flit_sender: FIFO-buffered flit source that requests an output port,
// sends PKT_LEN-flit packets on grant. Optional macro FLIT_SENDER_TIMEOUT_EN.
module flit_sender #(
    parameter int DATA_W  = 8,
    parameter int DEPTH   = 4,
    parameter int PKT_LEN = 4,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              req,
    input  logic              gnt,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              busy,
    output logic              timeout_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int BW = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 ||
        PKT_LEN < 1 || TIMEOUT < 1) begin : g_bad_cfg
        $error("flit_sender: illegal parameter combination");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_SEND,
        S_RELEASE
    } state_t;

    state_t            state_q, state_d;
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic [BW-1:0]     beat_q, beat_d;
    logic              req_q, req_d;
    logic              busy_q, busy_d;
    logic [DATA_W-1:0] mem_q [DEPTH];

    logic empty;
    logic full;
    logic push;
    logic pop;
    logic expire;

    assign empty     = (count_q == '0);
    assign full      = (count_q == CW'(DEPTH));
    assign in_ready  = !full;
    assign push      = in_valid && !full;
    assign out_valid = (state_q == S_SEND) && gnt && !empty;
    assign pop       = out_valid;
    assign out_data  = mem_q[rd_ptr_q];
    assign req       = req_q;
    assign busy      = busy_q;

`ifdef FLIT_SENDER_TIMEOUT_EN
    localparam int WW = $clog2(TIMEOUT + 1);

    logic [WW-1:0] wait_q, wait_d;
    logic          tmo_q, tmo_d;

    assign expire      = (state_q == S_REQ) && !gnt &&
                         (wait_q == WW'(TIMEOUT - 1));
    assign timeout_err = tmo_q;

    // Counts only while parked in REQ without grant; any exit clears it.
    always_comb begin
        wait_d = '0;
        tmo_d  = expire;
        if (state_q == S_REQ && !gnt && !expire) begin
            wait_d = wait_q + WW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_q <= '0;
            tmo_q  <= 1'b0;
        end else begin
            wait_q <= wait_d;
            tmo_q  <= tmo_d;
        end
    end
`else
    assign expire      = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        case (state_q)
            S_IDLE: begin
                if (!empty) begin
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (gnt) begin
                    state_d = S_SEND;
                end else if (expire) begin
                    state_d = S_IDLE;
                end
            end
            S_SEND: begin
                if (pop) begin
                    if (beat_q == BW'(PKT_LEN - 1)) begin
                        beat_d  = '0;
                        state_d = S_RELEASE;
                    end else begin
                        beat_d = beat_q + BW'(1);
                    end
                end
            end
            S_RELEASE: begin
                // Hold off a new request until the old grant is gone.
                if (!gnt) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                beat_d  = '0;
            end
        endcase
        req_d  = (state_d == S_REQ) || (state_d == S_SEND);
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            beat_q   <= '0;
            req_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            beat_q   <= beat_d;
            req_q    <= req_d;
            busy_q   <= busy_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

endmodule

// File: tb/tb_flit_sender.sv
// tb_flit_sender: directed cycle-by-cycle check of flit_sender with
// default parameters (DATA_W=8, DEPTH=4, PKT_LEN=4, TIMEOUT=15).
module tb_flit_sender;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       req;
    logic       gnt;
    logic       out_valid;
    logic [7:0] out_data;
    logic       busy;
    logic       timeout_err;

    int n_vec = 0;
    int n_err = 0;

    flit_sender dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .req         (req),
        .gnt         (gnt),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic iv, input logic [7:0] d,
                         input logic g);
        in_valid = iv;
        in_data  = d;
        gnt      = g;
        #1;
    endtask

    // One clock cycle: apply inputs, check this cycle's outputs, advance.
    task automatic step(input string tag, input logic iv,
                        input logic [7:0] d, input logic g,
                        input logic er, input logic eov,
                        input logic [7:0] ed, input logic eb,
                        input logic erdy);
        drive(iv, d, g);
        chk({tag, ".req"}, req, er);
        chk({tag, ".ov"}, out_valid, eov);
        if (eov) chk({tag, ".data"}, out_data, ed);
        chk({tag, ".busy"}, busy, eb);
        chk({tag, ".rdy"}, in_ready, erdy);
        chk({tag, ".tmo"}, timeout_err, 1'b0);
        tick();
    endtask

    task automatic reset_outs(input string tag);
        chk({tag, ".req"}, req, 1'b0);
        chk({tag, ".ov"}, out_valid, 1'b0);
        chk({tag, ".busy"}, busy, 1'b0);
        chk({tag, ".rdy"}, in_ready, 1'b1);
        chk({tag, ".tmo"}, timeout_err, 1'b0);
    endtask

    // Four pushes with gnt low, grant 2 cycles after req, drain, release.
    task automatic pkt4(input string t, input logic [7:0] b);
        step({t, "_p1"}, 1, b,         0, 0, 0, 0, 0, 1);
        step({t, "_p2"}, 1, b + 8'd1,  0, 0, 0, 0, 0, 1);
        step({t, "_p3"}, 1, b + 8'd2,  0, 1, 0, 0, 1, 1);
        step({t, "_p4"}, 1, b + 8'd3,  0, 1, 0, 0, 1, 1);
        step({t, "_g"},  0, 0,         1, 1, 0, 0, 1, 0);
        step({t, "_b1"}, 0, 0,         1, 1, 1, b,        1, 0);
        step({t, "_b2"}, 0, 0,         1, 1, 1, b + 8'd1, 1, 1);
        step({t, "_b3"}, 0, 0,         1, 1, 1, b + 8'd2, 1, 1);
        step({t, "_b4"}, 0, 0,         1, 1, 1, b + 8'd3, 1, 1);
        step({t, "_r1"}, 0, 0,         1, 0, 0, 0, 1, 1);
        step({t, "_r2"}, 0, 0,         0, 0, 0, 0, 1, 1);
        step({t, "_id"}, 0, 0,         0, 0, 0, 0, 0, 1);
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        gnt      = 1'b0;
        repeat (3) tick();
        reset_outs("rst0");
        rst = 1'b0;

        // Basic packet with delayed grant
        pkt4("t30", 8'h11);

        // Fill past depth, then a packet with a 3-cycle grant gap
        step("t31_1",  1, 8'h21, 0, 0, 0, 0,     0, 1);
        step("t31_2",  1, 8'h22, 0, 0, 0, 0,     0, 1);
        step("t31_3",  1, 8'h23, 0, 1, 0, 0,     1, 1);
        step("t31_4",  1, 8'h24, 0, 1, 0, 0,     1, 1);
        step("t31_5",  1, 8'h25, 0, 1, 0, 0,     1, 0);
        step("t31_6",  1, 8'h25, 0, 1, 0, 0,     1, 0);
        step("t31_7",  1, 8'h25, 1, 1, 0, 0,     1, 0);
        step("t31_8",  1, 8'h25, 1, 1, 1, 8'h21, 1, 0);
        step("t31_9",  1, 8'h25, 1, 1, 1, 8'h22, 1, 1);
        step("t31_10", 0, 0,     1, 1, 1, 8'h23, 1, 1);
        step("t31_11", 0, 0,     1, 1, 1, 8'h24, 1, 1);
        step("t31_12", 1, 8'h26, 0, 0, 0, 0,     1, 1);
        step("t31_13", 1, 8'h27, 0, 0, 0, 0,     0, 1);
        step("t31_14", 1, 8'h28, 0, 1, 0, 0,     1, 1);
        step("t32_g",  0, 0,     1, 1, 0, 0,     1, 0);
        step("t32_b1", 0, 0,     1, 1, 1, 8'h25, 1, 0);
        step("t32_b2", 0, 0,     1, 1, 1, 8'h26, 1, 1);
        step("t32_s1", 0, 0,     0, 1, 0, 0,     1, 1);
        step("t32_s2", 0, 0,     0, 1, 0, 0,     1, 1);
        step("t32_s3", 0, 0,     0, 1, 0, 0,     1, 1);
        step("t32_b3", 0, 0,     1, 1, 1, 8'h27, 1, 1);
        step("t32_b4", 0, 0,     1, 1, 1, 8'h28, 1, 1);
        step("t32_r1", 0, 0,     1, 0, 0, 0,     1, 1);
        step("t32_r2", 0, 0,     0, 0, 0, 0,     1, 1);
        step("t32_id", 0, 0,     0, 0, 0, 0,     0, 1);

        // Eight flits, back-to-back packets under a held grant
        step("t35_1",  1, 8'h51, 0, 0, 0, 0,     0, 1);
        step("t35_2",  1, 8'h52, 0, 0, 0, 0,     0, 1);
        step("t35_3",  1, 8'h53, 0, 1, 0, 0,     1, 1);
        step("t35_4",  1, 8'h54, 1, 1, 0, 0,     1, 1);
        step("t35_5",  1, 8'h55, 1, 1, 1, 8'h51, 1, 0);
        step("t35_6",  1, 8'h55, 1, 1, 1, 8'h52, 1, 1);
        step("t35_7",  1, 8'h56, 1, 1, 1, 8'h53, 1, 1);
        step("t35_8",  1, 8'h57, 1, 1, 1, 8'h54, 1, 1);
        step("t35_9",  1, 8'h58, 1, 0, 0, 0,     1, 1);
        step("t35_10", 0, 0,     0, 0, 0, 0,     1, 0);
        step("t35_11", 0, 0,     0, 0, 0, 0,     0, 0);
        step("t35_12", 0, 0,     0, 1, 0, 0,     1, 0);
        step("t35_13", 0, 0,     1, 1, 0, 0,     1, 0);
        step("t35_14", 0, 0,     1, 1, 1, 8'h55, 1, 0);
        step("t35_15", 0, 0,     1, 1, 1, 8'h56, 1, 1);
        step("t35_16", 0, 0,     1, 1, 1, 8'h57, 1, 1);
        step("t35_17", 0, 0,     1, 1, 1, 8'h58, 1, 1);
        step("t35_18", 0, 0,     1, 0, 0, 0,     1, 1);
        step("t35_19", 0, 0,     0, 0, 0, 0,     1, 1);
        step("t35_20", 0, 0,     0, 0, 0, 0,     0, 1);

        // Reset mid-packet with two flits still queued
        step("t33_1",  1, 8'h31, 0, 0, 0, 0,     0, 1);
        step("t33_2",  1, 8'h32, 0, 0, 0, 0,     0, 1);
        step("t33_3",  1, 8'h33, 0, 1, 0, 0,     1, 1);
        step("t33_4",  1, 8'h34, 0, 1, 0, 0,     1, 1);
        step("t33_5",  0, 0,     1, 1, 0, 0,     1, 0);
        step("t33_6",  0, 0,     1, 1, 1, 8'h31, 1, 0);
        step("t33_7",  0, 0,     1, 1, 1, 8'h32, 1, 1);
        drive(0, 0, 1);
        chk("t33_pre.ov", out_valid, 1'b1);
        chk("t33_pre.data", out_data, 8'h33);
        rst = 1'b1;
        #1;
        reset_outs("t33_async");
        gnt = 1'b0;
        tick();
        tick();
        reset_outs("t33_held");
        rst = 1'b0;
        step("t33_q1", 0, 0, 0, 0, 0, 0, 0, 1);
        step("t33_q2", 0, 0, 0, 0, 0, 0, 0, 1);
        step("t33_q3", 0, 0, 0, 0, 0, 0, 0, 1);
        pkt4("t33n", 8'h41);

        // Grant withheld for a long time
        step("tmo_1", 1, 8'h61, 0, 0, 0, 0, 0, 1);
        step("tmo_2", 0, 0,     0, 0, 0, 0, 0, 1);
`ifdef FLIT_SENDER_TIMEOUT_EN
        for (int i = 0; i < 15; i++) step("tmo_w", 0, 0, 0, 1, 0, 0, 1, 1);
        drive(0, 0, 0);
        chk("tmo_p.tmo", timeout_err, 1'b1);
        chk("tmo_p.req", req, 1'b0);
        chk("tmo_p.busy", busy, 1'b0);
        tick();
        step("tmo_rq", 0, 0, 0, 1, 0, 0, 1, 1);
`else
        for (int i = 0; i < 17; i++) step("tmo_w", 0, 0, 0, 1, 0, 0, 1, 1);
`endif
        step("tmo_g",  0, 0, 1, 1, 0, 0,     1, 1);
        step("tmo_b1", 0, 0, 1, 1, 1, 8'h61, 1, 1);
        step("tmo_st", 0, 0, 1, 1, 0, 0,     1, 1);
        rst = 1'b1;
        gnt = 1'b0;
        #1;
        reset_outs("fin_rst");
        tick();
        rst = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
